// File: rtl/matrix_loader_pkg.sv
// matrix_loader_pkg
// Shared definitions for the packed-matrix path between the HPS register
// interface and the det5 determinant unit: matrix geometry, the loader FSM
// state encoding and a helper that locates an element inside the packed bus.
package matrix_loader_pkg;

  localparam int DIM = 5;
  localparam int EW  = 8;
  localparam int NEL = DIM * DIM;
  localparam int MW  = NEL * EW;
  localparam int CW  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } load_state_t;

  // Element 0 occupies the top byte of the bus, so element k's MSB sits
  // k elements below the bus MSB.
  function automatic logic [7:0] elem_msb(input logic [CW-1:0] idx);
    return 8'(MW - 1 - int'(idx) * EW);
  endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// matrix_loader_if
// Host-facing handshakes of the matrix loader.
//   in_valid/in_ready/in_data        : element stream, one element per transfer
//   res_valid/res_ready/res_det/ovf  : captured determinant result
// master = host side (drives elements, consumes results)
// slave  = loader side
interface matrix_loader_if;
  import matrix_loader_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] in_data;
  logic          res_valid;
  logic          res_ready;
  logic [EW-1:0] res_det;
  logic          res_ovf;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_det, res_ovf
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_det, res_ovf
  );

endinterface

// File: rtl/matrix_loader.sv
// matrix_loader
// Producer side of the packed-matrix interface consumed by det5. Collects
// DIM*DIM signed elements row-major, presents them on mat_out with mat_valid
// for CALC_LAT cycles, then captures det_in/ovf_in into a result register
// offered to the host under a valid/ready handshake.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clear      synchronous abort back to IDLE (wins over a same-cycle transfer)
//   host       element stream in, result stream out (slave modport)
//   mat_out    packed matrix, element k at [MW-1-k*EW -: EW]
//   mat_valid  mat_out complete and stable
//   det_in     determinant from det5
//   ovf_in     overflow flag from det5
//   busy       FSM is not in IDLE
module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int CALC_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  matrix_loader_if.slave       host,
  output logic [MW-1:0]        mat_out,
  output logic                 mat_valid,
  input  logic [EW-1:0]        det_in,
  input  logic                 ovf_in,
  output logic                 busy
);

  localparam int WW = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;

  load_state_t   state;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;
  logic          in_ready_q;
  logic          res_valid_q;
  logic [EW-1:0] res_det_q;
  logic          res_ovf_q;
  logic          xfer;

  assign xfer           = host.in_valid & in_ready_q;
  assign host.in_ready  = in_ready_q;
  assign host.res_valid = res_valid_q;
  assign host.res_det   = res_det_q;
  assign host.res_ovf   = res_ovf_q;

  // Single FSM with registered handshake outputs. mat_out is written only on
  // element transfers and is deliberately left alone by clear and by the
  // return to IDLE, so the last matrix stays visible until overwritten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      count       <= '0;
      wait_cnt    <= '0;
      mat_out     <= '0;
      mat_valid   <= 1'b0;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_det_q   <= '0;
      res_ovf_q   <= 1'b0;
      busy        <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      count       <= '0;
      wait_cnt    <= '0;
      mat_valid   <= 1'b0;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            mat_out[MW-1 -: EW] <= host.in_data;
            count               <= CW'(1);
            state               <= LOAD;
            busy                <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            mat_out[elem_msb(count) -: EW] <= host.in_data;
            if (count == CW'(NEL - 1)) begin
              state      <= WAIT;
              wait_cnt   <= '0;
              in_ready_q <= 1'b0;
              mat_valid  <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        WAIT: begin
          // The result is sampled at the end of the last WAIT cycle, after
          // det5 has seen a stable matrix for CALC_LAT cycles.
          if (wait_cnt == WW'(CALC_LAT - 1)) begin
            res_det_q   <= det_in;
            res_ovf_q   <= ovf_in;
            res_valid_q <= 1'b1;
            mat_valid   <= 1'b0;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        DONE: begin
          if (host.res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy        <= 1'b0;
            count       <= '0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader
// Directed bench for matrix_loader. det5 is represented by det_in/ovf_in
// driven with the determinant of each directed matrix, worked out by hand.
module tb_matrix_loader;
  import matrix_loader_pkg::*;

  logic          clk;
  logic          rst;
  logic          clear;
  logic [MW-1:0] mat_out;
  logic          mat_valid;
  logic [EW-1:0] det_in;
  logic          ovf_in;
  logic          busy;

  int checks;
  int errors;

  matrix_loader_if host_if ();

  matrix_loader #(.CALC_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .host      (host_if),
    .mat_out   (mat_out),
    .mat_valid (mat_valid),
    .det_in    (det_in),
    .ovf_in    (ovf_in),
    .busy      (busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [MW-1:0] SEQ_MAT =
    200'h0102030405060708090a0b0c0d0e0f10111213141516171819;

  // Diagonal matrix with value v on the main diagonal (k = 0, 6, 12, 18, 24)
  function automatic logic [MW-1:0] build_diag(input logic [7:0] v);
    logic [MW-1:0] m;
    m = '0;
    for (int k = 0; k < NEL; k++)
      if (k % 6 == 0) m[MW-1-k*EW -: EW] = v;
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [MW-1:0] observed,
                             input logic [MW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stream all 25 elements of m, one per cycle, back to back
  task automatic applyStimulus(input logic [MW-1:0] m);
    for (int k = 0; k < NEL; k++) begin
      host_if.in_valid = 1'b1;
      host_if.in_data  = m[MW-1-k*EW -: EW];
      tick(1);
    end
    host_if.in_valid = 1'b0;
  endtask

  logic [MW-1:0] ident;
  logic [MW-1:0] expm;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    clear = 1'b0;
    det_in = '0;
    ovf_in = 1'b0;
    host_if.in_valid  = 1'b0;
    host_if.in_data   = '0;
    host_if.res_ready = 1'b0;
    ident = build_diag(8'd1);

    // Reset values
    #12;
    checkOutput("rst_in_ready", 200'(host_if.in_ready), 200'd1);
    checkOutput("rst_mat_valid", 200'(mat_valid), 200'd0);
    checkOutput("rst_res_valid", 200'(host_if.res_valid), 200'd0);
    checkOutput("rst_mat_out", mat_out, '0);
    checkOutput("rst_busy", 200'(busy), 200'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(1);

    // Sequential stream 0x01..0x19 (rank-deficient, det 0)
    det_in = 8'd0;
    ovf_in = 1'b0;
    for (int k = 0; k < NEL; k++) begin
      host_if.in_valid = 1'b1;
      host_if.in_data  = 8'(k + 1);
      if (k == NEL - 1)
        checkOutput("seq_ready_before_last", 200'(host_if.in_ready), 200'd1);
      tick(1);
    end
    checkOutput("seq_mat_out", mat_out, SEQ_MAT);
    checkOutput("seq_ready_low", 200'(host_if.in_ready), 200'd0);
    checkOutput("seq_mat_valid", 200'(mat_valid), 200'd1);
    // Extra element offered during WAIT must be ignored
    host_if.in_data = 8'hAA;
    tick(1);
    host_if.in_valid = 1'b0;
    checkOutput("seq_no_26th", mat_out, SEQ_MAT);
    checkOutput("seq_wait2_res_valid", 200'(host_if.res_valid), 200'd0);
    tick(1);
    checkOutput("seq_res_valid", 200'(host_if.res_valid), 200'd1);
    checkOutput("seq_mat_valid_drop", 200'(mat_valid), 200'd0);
    checkOutput("seq_res_det", 200'(host_if.res_det), 200'd0);
    host_if.res_ready = 1'b1;
    tick(1);
    host_if.res_ready = 1'b0;

    // Identity: det 1, result held through 3 cycles of res_ready=0
    det_in = 8'd1;
    ovf_in = 1'b0;
    applyStimulus(ident);
    checkOutput("id_mat_out", mat_out, ident);
    tick(1);
    checkOutput("id_res_not_yet", 200'(host_if.res_valid), 200'd0);
    tick(1);
    checkOutput("id_res_valid", 200'(host_if.res_valid), 200'd1);
    checkOutput("id_res_det", 200'(host_if.res_det), 200'd1);
    checkOutput("id_res_ovf", 200'(host_if.res_ovf), 200'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("id_res_hold", 200'(host_if.res_valid), 200'd1);
    end
    host_if.res_ready = 1'b1;
    tick(1);
    host_if.res_ready = 1'b0;
    checkOutput("id_res_drop", 200'(host_if.res_valid), 200'd0);
    checkOutput("id_idle_ready", 200'(host_if.in_ready), 200'd1);
    checkOutput("id_idle_busy", 200'(busy), 200'd0);
    checkOutput("id_idle_mat_kept", mat_out, ident);

    // Diagonal of 2s: det 32; first element overwrites only element 0
    det_in = 8'd32;
    ovf_in = 1'b0;
    host_if.in_valid = 1'b1;
    host_if.in_data  = 8'd2;
    tick(1);
    host_if.in_valid = 1'b0;
    expm = ident;
    expm[MW-1 -: EW] = 8'd2;
    checkOutput("d2_stale_rest", mat_out, expm);
    checkOutput("d2_busy", 200'(busy), 200'd1);
    expm = build_diag(8'd2);
    for (int k = 1; k < NEL; k++) begin
      host_if.in_valid = 1'b1;
      host_if.in_data  = expm[MW-1-k*EW -: EW];
      tick(1);
    end
    host_if.in_valid = 1'b0;
    tick(2);
    checkOutput("d2_mat_out", mat_out, expm);
    checkOutput("d2_res_det", 200'(host_if.res_det), 200'd32);
    checkOutput("d2_res_ovf", 200'(host_if.res_ovf), 200'd0);
    host_if.res_ready = 1'b1;
    tick(1);
    host_if.res_ready = 1'b0;

    // Diagonal of 3s: det 243 does not fit, det5 reports low byte 0xF3 + ovf
    det_in = 8'hF3;
    ovf_in = 1'b1;
    applyStimulus(build_diag(8'd3));
    tick(2);
    checkOutput("d3_res_det", 200'(host_if.res_det), 200'hF3);
    checkOutput("d3_res_ovf", 200'(host_if.res_ovf), 200'd1);
    host_if.res_ready = 1'b1;
    tick(1);
    host_if.res_ready = 1'b0;

    // Clear after 10 elements; the element presented with clear is dropped
    expm = build_diag(8'd3);
    for (int k = 0; k < 10; k++) begin
      host_if.in_valid = 1'b1;
      host_if.in_data  = 8'h55;
      expm[MW-1-k*EW -: EW] = 8'h55;
      tick(1);
    end
    host_if.in_data = 8'h77;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    host_if.in_valid = 1'b0;
    checkOutput("clr_busy", 200'(busy), 200'd0);
    checkOutput("clr_in_ready", 200'(host_if.in_ready), 200'd1);
    checkOutput("clr_mat_valid", 200'(mat_valid), 200'd0);
    checkOutput("clr_mat_kept", mat_out, expm);
    checkOutput("clr_res_kept", 200'(host_if.res_det), 200'hF3);
    det_in = 8'd1;
    ovf_in = 1'b0;
    applyStimulus(ident);
    checkOutput("clr_reload_mat", mat_out, ident);
    checkOutput("clr_reload_valid", 200'(mat_valid), 200'd1);
    tick(2);
    checkOutput("clr_reload_det", 200'(host_if.res_det), 200'd1);
    checkOutput("clr_reload_rv", 200'(host_if.res_valid), 200'd1);
    host_if.res_ready = 1'b1;
    tick(1);
    host_if.res_ready = 1'b0;

    // Reset pulse in the middle of WAIT
    applyStimulus(build_diag(8'd2));
    checkOutput("rw_in_wait", 200'(mat_valid), 200'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rw_mat_valid", 200'(mat_valid), 200'd0);
    checkOutput("rw_mat_out", mat_out, '0);
    checkOutput("rw_res_det", 200'(host_if.res_det), 200'd0);
    checkOutput("rw_busy", 200'(busy), 200'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(2);
    checkOutput("rw_in_ready", 200'(host_if.in_ready), 200'd1);
    checkOutput("rw_res_valid", 200'(host_if.res_valid), 200'd0);

    // DONE with random in_valid and res_ready low: nothing accepted
    det_in = 8'd1;
    applyStimulus(ident);
    tick(2);
    checkOutput("dn_res_valid", 200'(host_if.res_valid), 200'd1);
    for (int i = 0; i < 8; i++) begin
      host_if.in_valid = 1'($urandom_range(0, 1));
      host_if.in_data  = 8'($urandom_range(0, 255));
      tick(1);
      checkOutput("dn_mat_kept", mat_out, ident);
    end
    checkOutput("dn_ready_low", 200'(host_if.in_ready), 200'd0);
    // res_ready with in_valid: element accepted only in IDLE next cycle
    host_if.in_valid  = 1'b1;
    host_if.in_data   = 8'h42;
    host_if.res_ready = 1'b1;
    tick(1);
    host_if.res_ready = 1'b0;
    checkOutput("dn_exit_no_accept", mat_out, ident);
    checkOutput("dn_exit_busy", 200'(busy), 200'd0);
    tick(1);
    host_if.in_valid = 1'b0;
    expm = ident;
    expm[MW-1 -: EW] = 8'h42;
    checkOutput("dn_idle_accept", mat_out, expm);
    checkOutput("dn_idle_busy", 200'(busy), 200'd1);

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
